any1_issue_stage: RTL

- Sits directly downstream of the ROB instruction scheduler.
- Captures the scheduler's per-cycle selection (ROB id plus selected entry) into a 2-deep issue buffer and presents it to the execution unit with a valid/ready handshake.
- Pulses a mark-out strobe back to the ROB so the entry's out/out2 flags are set.
- Suppresses duplicate selections caused by the one-cycle lag of the out flag, and discards everything on a pipeline flush.

---
 rtl/any1_pkg.sv | 29 ++
 rtl/any1_issue_dupchk.sv | 22 ++
 rtl/any1_issue_stage.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/any1_pkg.sv
// Shared ANY1 core types: ROB entry layout plus the issue-stage slot and state types.
package any1_pkg;

  localparam int ROB_ENTRIES  = 64;
  localparam int ISSUE_QDEPTH = 2;

  typedef struct packed {
    logic        v;
    logic        out;
    logic        out2;
    logic        done;
    logic [5:0]  rd;
    logic [31:0] ir;
    logic [31:0] pc;
  } sReorderEntry;

  typedef struct packed {
    logic         v;
    logic [5:0]   rid;
    sReorderEntry ent;
  } sIssueSlot;

  typedef enum logic [1:0] {
    IS_EMPTY = 2'd0,
    IS_ONE   = 2'd1,
    IS_FULL  = 2'd2
  } eIssueState;

endpackage

// File: rtl/any1_issue_dupchk.sv
// Flags a scheduler selection that is already buffered or is the entry being marked this cycle.
module any1_issue_dupchk #(
  parameter int NSLOT = 2,
  parameter int RIDW  = 6
) (
  input  logic [RIDW-1:0]             sel_rid,
  input  logic [NSLOT-1:0]            slot_v,
  input  logic [NSLOT-1:0][RIDW-1:0]  slot_rid,
  input  logic                        mark_v,
  input  logic [RIDW-1:0]             mark_rid,
  output logic                        dup
);

  logic [NSLOT-1:0] hit;

  for (genvar g = 0; g < NSLOT; g++) begin : g_cmp
    assign hit[g] = slot_v[g] && (slot_rid[g] == sel_rid);
  end

  assign dup = (|hit) || (mark_v && (mark_rid == sel_rid));

endmodule

// File: rtl/any1_issue_stage.sv
// Two-slot issue buffer between the ROB scheduler and the execution unit.
// Optional ANY1_ISSUE_PERF_EN adds issued/stall/duplicate event counters.
module any1_issue_stage
  import any1_pkg::*;
#(
  parameter int QDEPTH = ISSUE_QDEPTH,
  parameter int RIDW   = 6
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic [RIDW:0]      sel_i,
  input  sReorderEntry       sel_ent_i,
  input  logic               ex_rdy_i,
  output logic               ex_vld_o,
  output logic [RIDW-1:0]    ex_rid_o,
  output sReorderEntry       ex_ent_o,
  output logic               mark_out_o,
  output logic [RIDW-1:0]    mark_rid_o,
  output logic               full_o,
`ifdef ANY1_ISSUE_PERF_EN
  output logic [31:0]        perf_issued_o,
  output logic [31:0]        perf_stall_o,
  output logic [31:0]        perf_dup_o,
`endif
  output logic [1:0]         cnt_o
);

  sIssueSlot  slot_q [QDEPTH];
  logic       rd_ptr_q, wr_ptr_q;
  eIssueState state_q, state_d;
  logic       mark_q;
  logic [RIDW-1:0] mark_rid_q;

  logic            sel_vld;
  logic [RIDW-1:0] sel_rid;
  logic            dup, accept, xfer;
  logic [QDEPTH-1:0]           slot_v;
  logic [QDEPTH-1:0][RIDW-1:0] slot_rid;

  assign sel_vld = !sel_i[RIDW];
  assign sel_rid = sel_i[RIDW-1:0];

  for (genvar g = 0; g < QDEPTH; g++) begin : g_slot
    assign slot_v[g]   = slot_q[g].v;
    assign slot_rid[g] = slot_q[g].rid;
  end

  any1_issue_dupchk #(.NSLOT(QDEPTH), .RIDW(RIDW)) u_dupchk (
    .sel_rid  (sel_rid),
    .slot_v   (slot_v),
    .slot_rid (slot_rid),
    .mark_v   (mark_q),
    .mark_rid (mark_rid_q),
    .dup      (dup)
  );

  // Outputs come straight from the head slot registers; sel_i never reaches them combinationally.
  assign ex_vld_o   = slot_q[rd_ptr_q].v;
  assign ex_rid_o   = slot_q[rd_ptr_q].rid;
  assign ex_ent_o   = slot_q[rd_ptr_q].ent;
  assign mark_out_o = mark_q;
  assign mark_rid_o = mark_rid_q;
  assign full_o     = (state_q == IS_FULL);
  assign cnt_o      = state_q;

  assign xfer   = ex_vld_o && ex_rdy_i;
  assign accept = sel_vld && !full_o && !flush_i && !dup;

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IS_EMPTY;
    end else begin
      case (state_q)
        IS_EMPTY: if (accept) state_d = IS_ONE;
        IS_ONE: begin
          if (accept && !xfer)      state_d = IS_FULL;
          else if (!accept && xfer) state_d = IS_EMPTY;
        end
        IS_FULL:  if (xfer) state_d = IS_ONE;
        default:  state_d = IS_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IS_EMPTY;
    else         state_q <= state_d;
  end

  // In ONE with accept+transfer, wr_ptr already points at the free slot, so order is kept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < QDEPTH; i++) slot_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else if (flush_i) begin
      for (int i = 0; i < QDEPTH; i++) slot_q[i].v <= 1'b0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      if (xfer) begin
        slot_q[rd_ptr_q].v <= 1'b0;
        rd_ptr_q           <= ~rd_ptr_q;
      end
      if (accept) begin
        slot_q[wr_ptr_q].v   <= 1'b1;
        slot_q[wr_ptr_q].rid <= sel_rid;
        slot_q[wr_ptr_q].ent <= sel_ent_i;
        wr_ptr_q             <= ~wr_ptr_q;
      end
    end
  end

  // A mark pending at flush time is still delivered; flush only blocks new accepts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mark_q     <= 1'b0;
      mark_rid_q <= '0;
    end else begin
      mark_q <= accept;
      if (accept) mark_rid_q <= sel_rid;
    end
  end

`ifdef ANY1_ISSUE_PERF_EN
  logic dup_evt;
  assign dup_evt = sel_vld && !full_o && !flush_i && dup;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_issued_o <= '0;
      perf_stall_o  <= '0;
      perf_dup_o    <= '0;
    end else begin
      if (xfer)                   perf_issued_o <= perf_issued_o + 32'd1;
      if (ex_vld_o && !ex_rdy_i)  perf_stall_o  <= perf_stall_o + 32'd1;
      if (dup_evt)                perf_dup_o    <= perf_dup_o + 32'd1;
    end
  end
`endif

endmodule
